// File: rtl/pe_overlay_pkg.sv
// ----------------------------------------------------------------------------
// pe_overlay_pkg
// Shared definitions for the PE overlay link blocks.
//   arb_state_t          : link arbiter FSM states (ARB_IDLE, ARB_LOCKED)
//   LINK_WIDTH_DEFAULT   : default overlay link payload width (130)
//   STALL_LIMIT_DEFAULT  : default watchdog stall threshold in cycles (16)
// ----------------------------------------------------------------------------
package pe_overlay_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    localparam int LINK_WIDTH_DEFAULT  = 130;
    localparam int STALL_LIMIT_DEFAULT = 16;

endpackage

// File: rtl/pe_rr_pick.sv
// ----------------------------------------------------------------------------
// pe_rr_pick
// Combinational rotate-priority picker. Scans req_valid starting at rr_ptr
// and wrapping modulo NUM_REQ; the first valid index wins.
//   req_valid [NUM_REQ] in  : request vector
//   rr_ptr    [PTR_W]   in  : highest-priority index this cycle
//   grant     [NUM_REQ] out : one-hot winner (all zero when nothing valid)
//   grant_idx [PTR_W]   out : encoded winner (0 when nothing valid)
//   any_valid           out : at least one request is valid
// ----------------------------------------------------------------------------
module pe_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               any_valid
);

    int idx;

    // Walk the ring from the lowest to the highest priority so the
    // highest-priority valid requester is the one written last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = 0;
        any_valid = |req_valid;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/pe_link_arbiter.sv
// ----------------------------------------------------------------------------
// pe_link_arbiter
// Round-robin, packet-locking arbiter sharing one registered overlay link
// between NUM_REQ requesters. A winner owns the link until its last flit is
// accepted. Everything freezes while ap_start is low.
//
// Optional feature: define PE_LINK_ARB_WATCHDOG_EN to add a stall watchdog
// that abandons a lock whose owner stops presenting flits for STALL_LIMIT
// cycles and raises the sticky stall_err flag.
//
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   ap_start                   : enable; low = no grants, outputs hold
//   req_data  [NUM_REQ*DW]     : payloads, requester i at [i*DW +: DW]
//   req_valid [NUM_REQ]        : flit valid per requester
//   req_last  [NUM_REQ]        : last flit of packet per requester
//   req_ready [NUM_REQ]        : flit accepted this cycle (combinational)
//   out_data/out_valid/out_last: registered link output
//   out_ready                  : downstream accepts the link register
//   stall_err                  : sticky watchdog flag (0 without watchdog)
// ----------------------------------------------------------------------------
module pe_link_arbiter
    import pe_overlay_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = LINK_WIDTH_DEFAULT,
    parameter int PTR_W       = $clog2(NUM_REQ),
    parameter int STALL_LIMIT = STALL_LIMIT_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ap_start,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    output logic                          out_last,
    input  logic                          out_ready,
    output logic                          stall_err
);

    arb_state_t             state, state_next;
    logic [PTR_W-1:0]       rr_ptr, owner, pick_idx, acc_idx;
    logic [NUM_REQ-1:0]     pick_grant;
    logic                   pick_any, load, accept, acc_last, wd_fire;
    logic [DATA_WIDTH-1:0]  acc_data;
    logic [DATA_WIDTH-1:0]  data_p1;
    logic                   vld_p1, last_p1;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(NUM_REQ - 1)) return '0;
        else                          return p + 1'b1;
    endfunction

    // The link register may take a new value when it is empty or being drained.
    assign load = ap_start && (out_ready || !vld_p1);

    pe_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any_valid (pick_any)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ARB_IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE:   if (accept && !acc_last)             state_next = ARB_LOCKED;
            ARB_LOCKED: if ((accept && acc_last) || wd_fire) state_next = ARB_IDLE;
            default:                                         state_next = ARB_IDLE;
        endcase
    end

    // Output decode: in IDLE the picker chooses, in LOCKED only the owner
    // can be accepted; either way at most one ready bit is set.
    always_comb begin
        req_ready = '0;
        accept    = 1'b0;
        acc_idx   = pick_idx;
        case (state)
            ARB_IDLE: begin
                if (load && pick_any) begin
                    accept    = 1'b1;
                    req_ready = pick_grant;
                end
            end
            ARB_LOCKED: begin
                acc_idx = owner;
                if (load && req_valid[owner]) begin
                    accept           = 1'b1;
                    req_ready[owner] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign acc_last = req_last[acc_idx];
    assign acc_data = req_data[acc_idx*DATA_WIDTH +: DATA_WIDTH];

    // A finished packet (or an abandoned lock) hands priority to the next index.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
            owner  <= '0;
        end else begin
            if (accept && acc_last) rr_ptr <= ptr_inc(acc_idx);
            else if (wd_fire)       rr_ptr <= ptr_inc(owner);
            if (state == ARB_IDLE && accept && !acc_last) owner <= acc_idx;
        end
    end

    // ---- stage p1: link output register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            last_p1 <= 1'b0;
        end else if (load) begin
            vld_p1 <= accept;
            if (accept) begin
                data_p1 <= acc_data;
                last_p1 <= acc_last;
            end
        end
    end

    assign out_data  = data_p1;
    assign out_valid = vld_p1;
    assign out_last  = last_p1;

`ifdef PE_LINK_ARB_WATCHDOG_EN
    localparam int CNT_W = $clog2(STALL_LIMIT + 1);

    logic [CNT_W-1:0] stall_cnt;
    logic             stall_tick, stall_flag;

    // Fire on the tick that brings the count to STALL_LIMIT, so the FSM is
    // back in IDLE exactly STALL_LIMIT stalled cycles after the last flit.
    assign stall_tick = (state == ARB_LOCKED) && ap_start && !req_valid[owner];
    assign wd_fire    = stall_tick && (stall_cnt == CNT_W'(STALL_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt  <= '0;
            stall_flag <= 1'b0;
        end else begin
            if (state != ARB_LOCKED || accept || wd_fire) stall_cnt <= '0;
            else if (stall_tick)                          stall_cnt <= stall_cnt + 1'b1;
            if (wd_fire) stall_flag <= 1'b1;
        end
    end

    assign stall_err = stall_flag;
`else
    logic unused_stall_limit;

    assign wd_fire            = 1'b0;
    assign stall_err          = 1'b0;
    assign unused_stall_limit = (STALL_LIMIT != 0);
`endif

endmodule
